fifo_fwft_read_stage: RTL

First-word-fall-through read stage for the asynchronous FIFO, entirely in the read clock domain. It sits directly downstream of the read pointer and the FIFO memory read port. It issues pop requests against `r_empty`, captures words returned by the registered memory read port, and presents them on a valid/ready interface. A 2-entry output buffer (head plus skid) sustains one word per cycle under continuous `out_ready` and never drops or duplicates a word under backpressure.

---
 rtl/fifo_fwft_read_stage.sv | 93 +++++++++
 1 files changed

// File: rtl/fifo_fwft_read_stage.sv
// First-word-fall-through read stage: pops the FIFO against r_empty, captures the
// registered memory read data and presents it through a head+skid valid/ready buffer.
module fifo_fwft_read_stage #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  r_clk,
  input  logic                  r_rst_n,
  input  logic                  r_empty,
  output logic                  r_en,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [1:0]            stage_cnt
);

  localparam int unsigned CNT_W = 2;
  localparam int unsigned CMP_W = CNT_W + 1;

  logic [DATA_WIDTH-1:0] r_head;
  logic [DATA_WIDTH-1:0] r_skid;
  logic                  r_head_vld;
  logic                  r_skid_vld;
  logic                  r_inflight;

  logic [DATA_WIDTH-1:0] w_head_nxt;
  logic [DATA_WIDTH-1:0] w_skid_nxt;
  logic                  w_head_vld_nxt;
  logic                  w_skid_vld_nxt;
  logic [CNT_W-1:0]      w_cnt;
  logic                  w_fire;
  logic                  w_pop;

  // Words owned by the stage: buffered plus the one still in the memory read port.
  assign w_cnt  = CNT_W'(r_head_vld) + CNT_W'(r_skid_vld) + CNT_W'(r_inflight);
  assign w_fire = r_head_vld & out_ready;

  // Slot freed by this cycle's fire can be refilled by a pop issued in the same cycle.
  assign r_en  = r_rst_n & ((CMP_W'(w_cnt) - CMP_W'(w_fire)) < CMP_W'(2));
  assign w_pop = r_en & ~r_empty;

  assign out_data  = r_head;
  assign out_valid = r_head_vld;
  assign stage_cnt = w_cnt;

  // Head/skid update; an arrival is the word popped at the previous edge.
  always_comb begin
    w_head_nxt     = r_head;
    w_skid_nxt     = r_skid;
    w_head_vld_nxt = r_head_vld;
    w_skid_vld_nxt = r_skid_vld;
    if (r_inflight) begin
      if (!r_head_vld) begin
        w_head_nxt     = mem_rdata;
        w_head_vld_nxt = 1'b1;
      end else if (w_fire) begin
        if (r_skid_vld) begin
          w_head_nxt = r_skid;
          w_skid_nxt = mem_rdata;
        end else begin
          w_head_nxt = mem_rdata;
        end
      end else begin
        w_skid_nxt     = mem_rdata;
        w_skid_vld_nxt = 1'b1;
      end
    end else if (w_fire) begin
      if (r_skid_vld) begin
        w_head_nxt     = r_skid;
        w_skid_vld_nxt = 1'b0;
      end else begin
        w_head_vld_nxt = 1'b0;
      end
    end
  end

  always_ff @(posedge r_clk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      r_head     <= '0;
      r_skid     <= '0;
      r_head_vld <= 1'b0;
      r_skid_vld <= 1'b0;
      r_inflight <= 1'b0;
    end else begin
      r_head     <= w_head_nxt;
      r_skid     <= w_skid_nxt;
      r_head_vld <= w_head_vld_nxt;
      r_skid_vld <= w_skid_vld_nxt;
      r_inflight <= w_pop;
    end
  end

endmodule
